// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage multiply/divide unit signal bundle (issue side and HI/LO side).
interface md_unit_if;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        MDStall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    modport master (
        output Start, MDOp, SrcA, SrcB,
        input  Busy, MDStall, HI, LO, MDOut
    );

    modport slave (
        input  Start, MDOp, SrcA, SrcB,
        output Busy, MDStall, HI, LO, MDOut
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle mult/div unit owning HI/LO; result committed after a countdown.
// Optional madd/maddu/msub/msubu (MDOp 9..12) enabled by defining MDU_MADD_EN.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   ph, pl;
    logic          pend_we;
    logic          busy;

    logic          is_mul, is_div, is_acc, is_sub, op_signed;
    logic          idle_start, issue, mt_hi, mt_lo;

    logic [63:0]   a_ext, b_ext, prod, acc, mul_res;
    logic          a_neg, b_neg, div_ok;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_acc    = 1'b0;
        is_sub    = 1'b0;
        op_signed = 1'b0;
        case (md.MDOp)
            4'd1: begin is_mul = 1'b1; op_signed = 1'b1; end
            4'd2: begin is_mul = 1'b1; end
            4'd3: begin is_div = 1'b1; op_signed = 1'b1; end
            4'd4: begin is_div = 1'b1; end
`ifdef MDU_MADD_EN
            4'd9:  begin is_mul = 1'b1; is_acc = 1'b1; op_signed = 1'b1; end
            4'd10: begin is_mul = 1'b1; is_acc = 1'b1; end
            4'd11: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; op_signed = 1'b1; end
            4'd12: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign busy       = (cnt != '0);
    assign idle_start = md.Start & ~busy;
    assign issue      = idle_start & (is_mul | is_div);
    assign mt_hi      = idle_start & (md.MDOp == 4'd5);
    assign mt_lo      = idle_start & (md.MDOp == 4'd6);

    // Extending both operands to 64 bits lets one truncated multiplier serve signed and unsigned.
    assign a_ext   = {{32{op_signed & md.SrcA[31]}}, md.SrcA};
    assign b_ext   = {{32{op_signed & md.SrcB[31]}}, md.SrcB};
    assign prod    = a_ext * b_ext;
    assign acc     = {hi_q, lo_q};
    assign mul_res = is_acc ? (is_sub ? acc - prod : acc + prod) : prod;

    // Signed divide runs on magnitudes; quotient sign is the XOR, remainder follows the dividend.
    assign a_neg  = op_signed & md.SrcA[31];
    assign b_neg  = op_signed & md.SrcB[31];
    assign div_ok = (md.SrcB != 32'd0);
    assign a_mag  = a_neg ? (32'd0 - md.SrcA) : md.SrcA;
    assign b_mag  = ~div_ok ? 32'd1 : (b_neg ? (32'd0 - md.SrcB) : md.SrcB);
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            ph      <= 32'd0;
            pl      <= 32'd0;
            pend_we <= 1'b0;
        end else if (busy) begin
            if (cnt == CW'(1) && pend_we) begin
                hi_q <= ph;
                lo_q <= pl;
            end
            cnt <= cnt - CW'(1);
        end else if (issue) begin
            cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_we <= is_mul | div_ok;
            if (is_div) begin
                ph <= rem;
                pl <= quot;
            end else begin
                ph <= mul_res[63:32];
                pl <= mul_res[31:0];
            end
        end else if (mt_hi) begin
            hi_q <= md.SrcA;
        end else if (mt_lo) begin
            lo_q <= md.SrcA;
        end
    end

    assign md.Busy    = busy;
    assign md.MDStall = busy | (md.Start & (is_mul | is_div));
    assign md.HI      = hi_q;
    assign md.LO      = lo_q;
    assign md.MDOut   = (md.MDOp == 4'd7) ? hi_q :
                        (md.MDOp == 4'd8) ? lo_q : 32'd0;
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed plus random check of md_unit against an arithmetic HI/LO model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] hi_m, lo_m;

    md_unit_if mif ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: updates hi_m/lo_m and reports expected busy length and issue-cycle stall.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output bit stall);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     r, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        acc = {hi_m, lo_m};
        r = acc;
        cyc = 0;
        stall = 1'b0;
        case (op)
            4'd1: begin r = sa * sb; cyc = MC; end
            4'd2: begin r = ua * ub; cyc = MC; end
            4'd3: begin
                cyc = DC;
                if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                cyc = DC;
                if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd5: r = {a, lo_m};
            4'd6: r = {hi_m, a};
            4'd9:  if (MADD_EN) begin r = acc + sa * sb; cyc = MC; end
            4'd10: if (MADD_EN) begin r = acc + ua * ub; cyc = MC; end
            4'd11: if (MADD_EN) begin r = acc - sa * sb; cyc = MC; end
            4'd12: if (MADD_EN) begin r = acc - ua * ub; cyc = MC; end
            default: ;
        endcase
        stall = (cyc != 0);
        hi_m = r[63:32];
        lo_m = r[31:0];
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude);
        int exp_cyc, seen;
        bit exp_stall;
        logic [31:0] old_hi;
        old_hi = hi_m;
        model(op, a, b, exp_cyc, exp_stall);
        @(negedge clk);
        mif.Start = 1'b1; mif.MDOp = op; mif.SrcA = a; mif.SrcB = b;
        #1 chk({tag, " stall_issue"}, 64'(mif.MDStall), 64'(exp_stall));
        @(negedge clk);
        mif.Start = 1'b0; mif.MDOp = 4'd0;
        seen = 0;
        while (mif.Busy === 1'b1 && seen < 100) begin
            if (seen == 0) begin
                chk({tag, " stall_busy"}, 64'(mif.MDStall), 64'd1);
                chk({tag, " hi_hold"}, 64'(mif.HI), 64'(old_hi));
            end
            seen++;
            if (intrude && seen == 2) begin
                mif.Start = 1'b1; mif.MDOp = 4'd2;
                mif.SrcA = $urandom; mif.SrcB = $urandom;
            end
            @(negedge clk);
            mif.Start = 1'b0; mif.MDOp = 4'd0;
        end
        chk({tag, " busy_cycles"}, 64'(seen), 64'(exp_cyc));
        chk({tag, " hi"}, 64'(mif.HI), 64'(hi_m));
        chk({tag, " lo"}, 64'(mif.LO), 64'(lo_m));
        chk({tag, " stall_done"}, 64'(mif.MDStall), 64'd0);
    endtask

    task automatic check_mf(input string tag);
        @(negedge clk);
        mif.Start = 1'b0;
        mif.MDOp = 4'd7;
        #1 chk({tag, " mfhi"}, 64'(mif.MDOut), 64'(hi_m));
        mif.MDOp = 4'd8;
        #1 chk({tag, " mflo"}, 64'(mif.MDOut), 64'(lo_m));
        mif.MDOp = 4'd0;
        #1 chk({tag, " mdout_none"}, 64'(mif.MDOut), 64'd0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1;
        mif.Start = 1'b0; mif.MDOp = 4'd0; mif.SrcA = 32'd0; mif.SrcB = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst busy", 64'(mif.Busy), 64'd0);
        chk("rst stall", 64'(mif.MDStall), 64'd0);
        chk("rst hi", 64'(mif.HI), 64'd0);
        chk("rst lo", 64'(mif.LO), 64'd0);

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult hi_const", 64'(mif.HI), 64'hFFFF_FFFF);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu hi_const", 64'(mif.HI), 64'h1);
        chk("multu lo_const", 64'(mif.LO), 64'hFFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div lo_const", 64'(mif.LO), 64'hFFFF_FFFD);
        chk("div hi_const", 64'(mif.HI), 64'hFFFF_FFFF);
        run_op("mthi11", 4'd5, 32'h11, 32'd0, 1'b0);
        run_op("mtlo22", 4'd6, 32'h22, 32'd0, 1'b0);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 1'b0);
        chk("divu0 hi_const", 64'(mif.HI), 64'h11);
        chk("divu0 lo_const", 64'(mif.LO), 64'h22);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf lo_const", 64'(mif.LO), 64'h8000_0000);
        chk("divovf hi_const", 64'(mif.HI), 64'h0);
        run_op("mthi", 4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check_mf("mthi");
        run_op("mtlo", 4'd6, 32'h1234, 32'd0, 1'b0);
        check_mf("mtlo");
        run_op("div_intrude", 4'd3, 32'd100, 32'd7, 1'b1);

        // Reset on the third busy cycle aborts the multiply.
        @(negedge clk);
        mif.Start = 1'b1; mif.MDOp = 4'd1; mif.SrcA = 32'd3; mif.SrcB = 32'd4;
        @(negedge clk);
        mif.Start = 1'b0; mif.MDOp = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        #1;
        chk("abort busy", 64'(mif.Busy), 64'd0);
        chk("abort hi", 64'(mif.HI), 64'd0);
        chk("abort lo", 64'(mif.LO), 64'd0);
        repeat (MC + 2) @(negedge clk);
        chk("abort no_commit", 64'({mif.HI, mif.LO}), 64'd0);

        run_op("madd_sethi", 4'd5, 32'd0, 32'd0, 1'b0);
        run_op("madd_setlo", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("madd", 4'd9, 32'd1, 32'd1, 1'b0);
        run_op("msubu_sethi", 4'd5, 32'd0, 32'd0, 1'b0);
        run_op("msubu_setlo", 4'd6, 32'd0, 32'd0, 1'b0);
        run_op("msubu", 4'd12, 32'd1, 32'd2, 1'b0);
        run_op("msub", 4'd11, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("maddu", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(1, 12));
            if (rop == 4'd7 || rop == 4'd8) rop = 4'd1;
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, 1'b0);
            check_mf($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
